// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with combinational control outputs.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_reg_write,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_jump,
    input  logic        dec_noop,
    input  logic [2:0]  dec_alu_op,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_load,
    output logic        pc_write,
    output logic        rf_we,
    output logic        halted,
    output logic [1:0]  pc_src,
    output logic [2:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [2:0] ALU_BEQ = 3'b110;

    state_t state_q, state_d;

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path can infer a latch.
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;
        pc_src   = 2'b00;
        unique case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (dec_noop) begin
                    state_d = HALT;
                end else if (dec_jump) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                    state_d  = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (dec_alu_op == ALU_BEQ) begin
                    pc_write = alu_zero;
                    pc_src   = 2'b01;
                    state_d  = FETCH;
                end else if (dec_mem_read || dec_mem_write) begin
                    state_d = MEM;
                end else if (dec_reg_write) begin
                    state_d = WB;
                end else begin
                    state_d = FETCH;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = dec_mem_write & ~dec_mem_read;  // a load wins when both flags are set
                if (mem_ack) state_d = dec_mem_read ? WB : FETCH;
            end
            WB: begin
                rf_we   = 1'b1;
                state_d = FETCH;
            end
            HALT:    halted  = 1'b1;
            default: state_d = FETCH;
        endcase
        if (rst) begin
            state_d  = FETCH;
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            iord     = 1'b0;
            ir_load  = 1'b0;
            pc_write = 1'b0;
            rf_we    = 1'b0;
            halted   = 1'b0;
            pc_src   = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    assign state = rst ? 3'd0 : state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;
    logic        instr_done;

    // An instruction retires when control returns to FETCH from a later state, or halts.
    assign instr_done = ((state_d == FETCH) && (state_q inside {DECODE, EXEC, MEM, WB}))
                      || ((state_d == HALT) && (state_q != HALT));

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != HALT) cycle_q <= cycle_q + 32'd1;
            if (instr_done)      instr_q <= instr_q + 32'd1;
        end
    end

    assign cycle_count = rst ? 32'd0 : cycle_q;
    assign instr_count = rst ? 32'd0 : instr_q;
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected outputs are queued per cycle and a
// negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_reg_write = 1'b0, dec_mem_read = 1'b0, dec_mem_write = 1'b0;
    logic        dec_jump = 1'b0, dec_noop = 1'b0;
    logic [2:0]  dec_alu_op = 3'b000;
    logic        alu_zero = 1'b0, mem_ack = 1'b0;
    logic        mem_req, mem_we, iord, ir_load, pc_write, rf_we, halted;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [31:0] cycle_count, instr_count;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_jump(dec_jump), .dec_noop(dec_noop),
        .dec_alu_op(dec_alu_op), .alu_zero(alu_zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_load(ir_load),
        .pc_write(pc_write), .rf_we(rf_we), .halted(halted), .pc_src(pc_src),
        .state(state), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Decoder words: {reg_write, mem_read, mem_write, jump, noop, alu_op[2:0]}
    localparam logic [7:0] I_ADD   = 8'b10000_000;
    localparam logic [7:0] I_LW    = 8'b11000_000;
    localparam logic [7:0] I_SW    = 8'b00100_000;
    localparam logic [7:0] I_RW    = 8'b11100_000;
    localparam logic [7:0] I_BEQ   = 8'b00000_110;
    localparam logic [7:0] I_J     = 8'b00010_000;
    localparam logic [7:0] I_NONE  = 8'b00000_000;
    localparam logic [7:0] I_NOOPJ = 8'b00011_000;

    typedef struct {
        string       nm;
        logic [11:0] outs;
        logic [31:0] cc;
        logic [31:0] ic;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_c = 32'd0;
    logic [31:0] exp_i = 32'd0;
    int          prev_st = 0;
    bit          prev_r = 1'b1;

    // Output vector layout: {mem_req, mem_we, iord, ir_load, pc_write, rf_we, halted, pc_src, state}
    function automatic logic [11:0] mk(input logic [2:0] st, input bit req, input bit we,
                                       input bit ia, input bit irl, input bit pcw,
                                       input logic [1:0] src, input bit rfw, input bit hlt);
        return {req, we, ia, irl, pcw, rfw, hlt, src, st};
    endfunction

    // One clock: drive inputs, queue the expected response, advance past the next rising edge.
    task automatic cyc(input string nm, input bit r, input logic [7:0] dec,
                       input bit z, input bit ack, input logic [11:0] e);
        exp_t x;
        int   st;
        rst = r;
        {dec_reg_write, dec_mem_read, dec_mem_write, dec_jump, dec_noop, dec_alu_op} = dec;
        alu_zero = z;
        mem_ack  = ack;
        st = int'(e[2:0]);
        if (!r && !prev_r && (((prev_st >= 1) && (prev_st <= 4) && (st == 0)) ||
                              ((st == 5) && (prev_st != 5))))
            exp_i = exp_i + 32'd1;
        x.nm   = nm;
        x.outs = e;
        x.cc   = (PERF && !r) ? exp_c : 32'd0;
        x.ic   = (PERF && !r) ? exp_i : 32'd0;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (r) begin
            exp_c = 32'd0;
            exp_i = 32'd0;
        end else if (st != 5) begin
            exp_c = exp_c + 32'd1;
        end
        prev_st = st;
        prev_r  = r;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        x;
            logic [11:0] got;
            x   = exp_q.pop_front();
            got = {mem_req, mem_we, iord, ir_load, pc_write, rf_we, halted, pc_src, state};
            total++;
            if (got !== x.outs) begin
                bad++;
                $display("FAIL %s ctrl: got=%b want=%b", x.nm, got, x.outs);
            end
            total++;
            if (cycle_count !== x.cc) begin
                bad++;
                $display("FAIL %s cycle_count: got=%0d want=%0d", x.nm, cycle_count, x.cc);
            end
            total++;
            if (instr_count !== x.ic) begin
                bad++;
                $display("FAIL %s instr_count: got=%0d want=%0d", x.nm, instr_count, x.ic);
            end
        end
    end

    // Common expected vectors.
    function automatic logic [11:0] f_wait(); return mk(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 0); endfunction
    function automatic logic [11:0] f_ack();  return mk(3'd0, 1, 0, 0, 1, 1, 2'b00, 0, 0); endfunction
    function automatic logic [11:0] s_dec();  return mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0); endfunction
    function automatic logic [11:0] s_exec(); return mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0); endfunction
    function automatic logic [11:0] s_wb();   return mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 1, 0); endfunction
    function automatic logic [11:0] s_memr(); return mk(3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 0); endfunction
    function automatic logic [11:0] s_memw(); return mk(3'd3, 1, 1, 1, 0, 0, 2'b00, 0, 0); endfunction
    function automatic logic [11:0] s_halt(); return mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 1); endfunction

    task automatic test_reset();
        cyc("rst_idle",     1, I_ADD, 1, 1, 12'd0);
        cyc("rst_ack_high", 1, I_LW,  1, 1, 12'd0);
    endtask

    task automatic test_add();
        cyc("add_fetch_wait", 0, I_ADD, 0, 0, f_wait());
        cyc("add_fetch_ack",  0, I_ADD, 0, 1, f_ack());
        cyc("add_decode",     0, I_ADD, 0, 1, s_dec());
        cyc("add_exec",       0, I_ADD, 0, 1, s_exec());
        cyc("add_wb",         0, I_ADD, 0, 1, s_wb());
        cyc("add_refetch",    0, I_ADD, 0, 0, f_wait());
    endtask

    task automatic test_lw();
        cyc("lw_fetch",  0, I_LW, 0, 1, f_ack());
        cyc("lw_decode", 0, I_LW, 0, 0, s_dec());
        cyc("lw_exec",   0, I_LW, 0, 0, s_exec());
        cyc("lw_mem_w1", 0, I_LW, 0, 0, s_memr());
        cyc("lw_mem_w2", 0, I_LW, 0, 0, s_memr());
        cyc("lw_mem_ack",0, I_LW, 0, 1, s_memr());
        cyc("lw_wb",     0, I_LW, 0, 1, s_wb());
    endtask

    task automatic test_sw();
        cyc("sw_fetch",   0, I_SW, 0, 1, f_ack());
        cyc("sw_decode",  0, I_SW, 0, 0, s_dec());
        cyc("sw_exec",    0, I_SW, 0, 0, s_exec());
        cyc("sw_mem_ack", 0, I_SW, 0, 1, s_memw());
    endtask

    task automatic test_rw_both();
        cyc("rw_fetch",   0, I_RW, 0, 1, f_ack());
        cyc("rw_decode",  0, I_RW, 0, 0, s_dec());
        cyc("rw_exec",    0, I_RW, 0, 0, s_exec());
        cyc("rw_mem_ack", 0, I_RW, 0, 1, s_memr());
        cyc("rw_wb",      0, I_RW, 0, 0, s_wb());
    endtask

    task automatic test_beq();
        cyc("beq1_fetch",  0, I_BEQ, 0, 1, f_ack());
        cyc("beq1_decode", 0, I_BEQ, 0, 0, s_dec());
        cyc("beq1_exec",   0, I_BEQ, 1, 1, mk(3'd2, 0, 0, 0, 0, 1, 2'b01, 0, 0));
        cyc("beq0_fetch",  0, I_BEQ, 0, 1, f_ack());
        cyc("beq0_decode", 0, I_BEQ, 0, 0, s_dec());
        cyc("beq0_exec",   0, I_BEQ, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 2'b01, 0, 0));
    endtask

    task automatic test_jump();
        cyc("j_fetch",  0, I_J, 0, 1, f_ack());
        cyc("j_decode", 0, I_J, 0, 1, mk(3'd1, 0, 0, 0, 0, 1, 2'b10, 0, 0));
    endtask

    task automatic test_exec_none();
        cyc("none_fetch",  0, I_NONE, 0, 1, f_ack());
        cyc("none_decode", 0, I_NONE, 0, 0, s_dec());
        cyc("none_exec",   0, I_NONE, 0, 0, s_exec());
        cyc("none_after",  0, I_NONE, 0, 0, f_wait());
    endtask

    task automatic test_reset_mid_mem();
        cyc("rsw_fetch",    0, I_SW, 0, 1, f_ack());
        cyc("rsw_decode",   0, I_SW, 0, 0, s_dec());
        cyc("rsw_exec",     0, I_SW, 0, 0, s_exec());
        cyc("rsw_mem_wait", 0, I_SW, 0, 0, s_memw());
        cyc("rsw_reset",    1, I_SW, 0, 1, 12'd0);
        cyc("rsw_after",    0, I_SW, 0, 0, f_wait());
        cyc("rsw_late_ack", 0, I_ADD, 0, 1, f_ack());
        cyc("rsw_decode2",  0, I_ADD, 0, 0, s_dec());
        cyc("rsw_exec2",    0, I_ADD, 0, 0, s_exec());
        cyc("rsw_wb2",      0, I_ADD, 0, 0, s_wb());
    endtask

    task automatic test_wrap();
`ifdef MULTICYCLE_CTRL_PERF_EN
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        exp_c = 32'hFFFF_FFFE;
        cyc("wrap_fetch",  0, I_ADD, 0, 1, f_ack());
        cyc("wrap_decode", 0, I_ADD, 0, 0, s_dec());
        cyc("wrap_exec",   0, I_ADD, 0, 0, s_exec());
        cyc("wrap_wb",     0, I_ADD, 0, 0, s_wb());
`endif
    endtask

    task automatic test_halt();
        cyc("halt_fetch",  0, I_NOOPJ, 0, 1, f_ack());
        cyc("halt_decode", 0, I_NOOPJ, 0, 1, s_dec());
        cyc("halt_1",      0, I_NOOPJ, 0, 1, s_halt());
        cyc("halt_2",      0, I_LW,    1, 1, s_halt());
        cyc("halt_3",      0, I_J,     0, 0, s_halt());
        cyc("halt_rst",    1, I_ADD,   0, 0, 12'd0);
        cyc("halt_exit",   0, I_ADD,   0, 0, f_wait());
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_rw_both();
        test_beq();
        test_jump();
        test_exec_none();
        test_reset_mid_mem();
        test_wrap();
        test_halt();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports dec_reg_write, dec_mem_read, dec_mem_write, dec_jump, dec_noop  input  1 each  decoder control flags for the instruction held in IR.
REQ-004 SHALL have port dec_alu_op  input  3  decoder ALU op; value 3'b110 marks a branch (beq).
REQ-005 SHALL have port alu_zero  input  1  ALU zero flag, valid in EXEC.
REQ-006 SHALL have port mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-007 SHALL have ports mem_req, mem_we, iord  output  1 each  memory request, write enable, address select (0=PC, 1=ALU result).
REQ-008 SHALL have ports ir_load, pc_write, rf_we, halted  output  1 each  IR load, PC load, register-file write, halted status.
REQ-009 SHALL have port pc_src  output  2  PC source: 00=PC+4, 01=branch target, 10=jump target.
REQ-010 SHALL have port state  output  3  current state encoding.
REQ-011 SHALL have ports cycle_count, instr_count  output  32 each  performance counters.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6-7 go to FETCH next cycle.
REQ-013 Outputs SHALL be combinational from state and inputs; all unlisted outputs 0 in each state.
REQ-014 FETCH: mem_req=1, iord=0, mem_we=0; without mem_ack stay in FETCH; with mem_ack assert ir_load=1, pc_write=1, pc_src=00 that cycle, then go to DECODE.
REQ-015 DECODE (1 cycle): dec_noop -> HALT (noop wins over jump); else dec_jump -> pc_write=1, pc_src=10, go to FETCH; else go to EXEC.
REQ-016 EXEC (1 cycle): dec_alu_op=110 -> pc_write=alu_zero, pc_src=01, go to FETCH; else mem_read|mem_write -> MEM; else dec_reg_write -> WB; else FETCH.
REQ-017 MEM: mem_req=1, iord=1, mem_we=dec_mem_write; hold until mem_ack; on ack go to WB if dec_mem_read, else FETCH; if both flags set, read takes priority and mem_we=0.
REQ-018 WB (1 cycle): rf_we=1, then go to FETCH.
REQ-019 HALT: halted=1, all other control outputs 0; exit only via rst.
REQ-020 mem_ack in DECODE, EXEC, WB or HALT SHALL be ignored.
REQ-021 Latency: R-type/addi = 4 cycles plus fetch wait; lw = 5 cycles plus 2 waits; sw = 4 plus 2 waits; beq = 3 plus wait; j = 2 plus wait.

Reset
REQ-022 While rst=1: state=FETCH, counters=0, and every output forced 0, including mem_req.
REQ-023 Reset asserted mid-MEM or mid-FETCH SHALL abandon the request; a late mem_ack after reset SHALL have no effect except as a FETCH ack.
REQ-024 The first FETCH request SHALL be in the first cycle after rst deasserts.

Configuration
REQ-025 Macro MULTICYCLE_CTRL_PERF_EN defined: cycle_count SHALL increment each non-reset cycle not in HALT; instr_count SHALL increment on each transition into FETCH from DECODE/EXEC/MEM/WB and into HALT; both wrap 0xFFFFFFFF->0.
REQ-026 Macro undefined: cycle_count and instr_count SHALL be tied to 0, with no counter registers.

Verification
REQ-027 add (dec_reg_write=1, alu_op=000), mem_ack=1 in FETCH -> states 0,1,2,4,0; rf_we high exactly one cycle; instr_count +1.
REQ-028 lw with mem_ack delayed 3 cycles in MEM -> MEM held 3 cycles with iord=1, mem_we=0, then WB with rf_we=1.
REQ-029 beq with alu_zero=1 -> pc_write=1, pc_src=01 in EXEC; with alu_zero=0 -> pc_write=0; next state FETCH in both cases.
REQ-030 dec_noop=1 and dec_jump=1 in DECODE -> HALT, halted=1, pc_write=0; cycle_count frozen; rst -> FETCH.
REQ-031 rst pulsed during MEM of sw -> mem_req=0 during reset, state=0 after, counters=0 (PERF_EN).
REQ-032 PERF_EN with cycle_count forced near 0xFFFFFFFF -> wraps to 0 without affecting the FSM.
